// File: rtl/mem_stage_lsu_if.sv
// Data-memory port bundle between the MEM stage and data memory.
//   master (LSU side): drives dmem_req/we/addr/wstrb/wdata; receives dmem_gnt/rvalid/rdata.
//   slave  (memory)  : the mirror image.
// dmem_addr is always word aligned; dmem_wstrb selects the byte lanes of a store.
interface mem_stage_lsu_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wstrb,
        output dmem_wdata,
        input  dmem_gnt,
        input  dmem_rvalid,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wstrb,
        input  dmem_wdata,
        output dmem_gnt,
        output dmem_rvalid,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-access stage of the 5-stage RV32I pipeline.
// Runs loads/stores over a request/grant/response port, steers store bytes onto
// lanes, extends load data, and passes non-memory results through to MEM/WB.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   in_valid .. op_in   EX/MEM pipeline register contents
//   stall_out           hold EX/MEM (combinational)
//   dmem                data-memory port (master side)
//   wb_*                registered MEM/WB contents
//   mem_exc, exc_addr   one-cycle misaligned/illegal access pulse and faulting address
module mem_stage_lsu (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [31:0]            alu_result_in,
    input  logic [31:0]            rs2_data_in,
    input  logic [2:0]             funct3_in,
    input  logic [4:0]             rd_in,
    input  logic                   regwrite_in,
    input  logic [6:0]             op_in,
    output logic                   stall_out,
    mem_stage_lsu_if.master        dmem,
    output logic                   wb_valid,
    output logic [31:0]            wb_data,
    output logic [4:0]             wb_rd,
    output logic                   wb_regwrite,
    output logic                   mem_exc,
    output logic [31:0]            exc_addr
);

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e state_q, state_d;

    // Captured transaction
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic [4:0]  rd_q;
    logic        regwrite_q;
    logic        we_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wdata_q;
    logic        capture;

    // MEM/WB registers
    logic        wb_valid_q, wb_valid_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_regwrite_q, wb_regwrite_d;
    logic        mem_exc_q, mem_exc_d;
    logic [31:0] exc_addr_q, exc_addr_d;

    logic        stall;

    // ------------------------------------------------------------------
    // Decode and legality of the incoming instruction
    // ------------------------------------------------------------------
    logic        is_load, is_store, is_mem;
    logic        f3_ok, align_ok, legal;
    logic [3:0]  wstrb_steer;
    logic [31:0] wdata_steer;

    assign is_load  = (op_in == OpLoad);
    assign is_store = (op_in == OpStore);
    assign is_mem   = is_load | is_store;

    always_comb begin
        if (is_load) begin
            f3_ok = !(funct3_in == 3'b011 || funct3_in == 3'b110 || funct3_in == 3'b111);
        end else begin
            f3_ok = (funct3_in < 3'b011);
        end

        case (funct3_in[1:0])
            2'b01:   align_ok = ~alu_result_in[0];
            2'b10:   align_ok = (alu_result_in[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase

        legal = f3_ok & align_ok;
    end

    // Store data is replicated across lanes so memory only needs the strobes
    always_comb begin
        wstrb_steer = 4'b0000;
        wdata_steer = 32'h0;
        if (is_store) begin
            case (funct3_in[1:0])
                2'b00: begin
                    wdata_steer = {4{rs2_data_in[7:0]}};
                    wstrb_steer = 4'b0001 << alu_result_in[1:0];
                end
                2'b01: begin
                    wdata_steer = {2{rs2_data_in[15:0]}};
                    wstrb_steer = 4'b0011 << alu_result_in[1:0];
                end
                default: begin
                    wdata_steer = rs2_data_in;
                    wstrb_steer = 4'b1111;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Load extraction
    // ------------------------------------------------------------------
    logic [31:0] byte_shift, half_shift, load_data;

    assign byte_shift = dmem.dmem_rdata >> {addr_q[1:0], 3'b000};
    assign half_shift = dmem.dmem_rdata >> {addr_q[1], 4'b0000};

    always_comb begin
        case (funct3_q)
            3'b000:  load_data = {{24{byte_shift[7]}}, byte_shift[7:0]};
            3'b001:  load_data = {{16{half_shift[15]}}, half_shift[15:0]};
            3'b100:  load_data = {24'h0, byte_shift[7:0]};
            3'b101:  load_data = {16'h0, half_shift[15:0]};
            default: load_data = dmem.dmem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM and MEM/WB next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        capture       = 1'b0;
        stall         = 1'b0;
        wb_valid_d    = 1'b0;
        wb_regwrite_d = 1'b0;
        wb_data_d     = wb_data_q;
        wb_rd_d       = wb_rd_q;
        mem_exc_d     = 1'b0;
        exc_addr_d    = exc_addr_q;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (is_mem && legal) begin
                        stall   = 1'b1;
                        capture = 1'b1;
                        state_d = StReq;
                    end else if (is_mem) begin
                        // Faulting access retires without a register write
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_in;
                        mem_exc_d  = 1'b1;
                        exc_addr_d = alu_result_in;
                    end else begin
                        wb_valid_d    = 1'b1;
                        wb_data_d     = alu_result_in;
                        wb_rd_d       = rd_in;
                        wb_regwrite_d = regwrite_in & (rd_in != 5'd0);
                    end
                end
            end
            StReq: begin
                stall = 1'b1;
                if (dmem.dmem_gnt) begin
                    if (we_q) begin
                        // Release upstream on the same edge the store retires
                        stall      = 1'b0;
                        state_d    = StIdle;
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                stall = 1'b1;
                if (dmem.dmem_rvalid) begin
                    stall         = 1'b0;
                    state_d       = StIdle;
                    wb_valid_d    = 1'b1;
                    wb_data_d     = load_data;
                    wb_rd_d       = rd_q;
                    wb_regwrite_d = regwrite_q & (rd_q != 5'd0);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Reset must drop stall immediately even if a memory op sits in EX/MEM
    assign stall_out = stall & ~reset;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            wb_valid_q    <= 1'b0;
            wb_data_q     <= 32'h0;
            wb_rd_q       <= 5'd0;
            wb_regwrite_q <= 1'b0;
            mem_exc_q     <= 1'b0;
            exc_addr_q    <= 32'h0;
        end else begin
            state_q       <= state_d;
            wb_valid_q    <= wb_valid_d;
            wb_data_q     <= wb_data_d;
            wb_rd_q       <= wb_rd_d;
            wb_regwrite_q <= wb_regwrite_d;
            mem_exc_q     <= mem_exc_d;
            exc_addr_q    <= exc_addr_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q     <= 32'h0;
            funct3_q   <= 3'b000;
            rd_q       <= 5'd0;
            regwrite_q <= 1'b0;
            we_q       <= 1'b0;
            wstrb_q    <= 4'b0000;
            wdata_q    <= 32'h0;
        end else if (capture) begin
            addr_q     <= alu_result_in;
            funct3_q   <= funct3_in;
            rd_q       <= rd_in;
            regwrite_q <= regwrite_in;
            we_q       <= is_store;
            wstrb_q    <= wstrb_steer;
            wdata_q    <= wdata_steer;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign dmem.dmem_req   = (state_q == StReq);
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = {addr_q[31:2], 2'b00};
    assign dmem.dmem_wstrb = wstrb_q;
    assign dmem.dmem_wdata = wdata_q;

    assign wb_valid    = wb_valid_q;
    assign wb_data     = wb_data_q;
    assign wb_rd       = wb_rd_q;
    assign wb_regwrite = wb_regwrite_q;
    assign mem_exc     = mem_exc_q;
    assign exc_addr    = exc_addr_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu. Inputs change and outputs are sampled
// around the falling clock edge; the DUT acts on the rising edge.
module tb_mem_stage_lsu;

    localparam logic [6:0] OpAlu   = 7'b0110011;
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] alu_result_in;
    logic [31:0] rs2_data_in;
    logic [2:0]  funct3_in;
    logic [4:0]  rd_in;
    logic        regwrite_in;
    logic [6:0]  op_in;
    logic        stall_out;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic        mem_exc;
    logic [31:0] exc_addr;

    int checks = 0;
    int errors = 0;

    mem_stage_lsu_if dmem_bus ();

    mem_stage_lsu dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .alu_result_in (alu_result_in),
        .rs2_data_in   (rs2_data_in),
        .funct3_in     (funct3_in),
        .rd_in         (rd_in),
        .regwrite_in   (regwrite_in),
        .op_in         (op_in),
        .stall_out     (stall_out),
        .dmem          (dmem_bus),
        .wb_valid      (wb_valid),
        .wb_data       (wb_data),
        .wb_rd         (wb_rd),
        .wb_regwrite   (wb_regwrite),
        .mem_exc       (mem_exc),
        .exc_addr      (exc_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_instr(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] alu,
                               input logic [31:0] rs2, input logic [4:0] rd, input logic rw);
        in_valid      = 1'b1;
        op_in         = op;
        funct3_in     = f3;
        alu_result_in = alu;
        rs2_data_in   = rs2;
        rd_in         = rd;
        regwrite_in   = rw;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        // Legal load presented during reset must not raise stall
        drive_instr(OpLoad, 3'b010, 32'h0000_0100, 32'h0, 5'd1, 1'b1);
        #1;
        checks++;
        if ({dmem_bus.dmem_req, stall_out} !== 2'b00) begin
            errors++;
            $display("FAIL reset_req_stall: got %b expected 00", {dmem_bus.dmem_req, stall_out});
        end
        checks++;
        if ({wb_valid, wb_regwrite, mem_exc, wb_rd, wb_data, exc_addr} !== 72'h0) begin
            errors++;
            $display("FAIL reset_wb: got %h expected 0",
                     {wb_valid, wb_regwrite, mem_exc, wb_rd, wb_data, exc_addr});
        end
        checks++;
        if ({dmem_bus.dmem_we, dmem_bus.dmem_wstrb, dmem_bus.dmem_addr, dmem_bus.dmem_wdata} !== 69'h0) begin
            errors++;
            $display("FAIL reset_bus: got %h expected 0",
                     {dmem_bus.dmem_we, dmem_bus.dmem_wstrb, dmem_bus.dmem_addr, dmem_bus.dmem_wdata});
        end
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_passthrough();
        drive_instr(OpAlu, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
        #1;
        checks++;
        if ({stall_out, dmem_bus.dmem_req} !== 2'b00) begin
            errors++;
            $display("FAIL pass_stall: got %b expected 00", {stall_out, dmem_bus.dmem_req});
        end
        @(negedge clk);
        checks++;
        if ({wb_valid, wb_regwrite, wb_rd, wb_data} !== {1'b1, 1'b1, 5'd5, 32'h0000_1234}) begin
            errors++;
            $display("FAIL pass_wb: got v=%b rw=%b rd=%0d data=%h expected v=1 rw=1 rd=5 data=00001234",
                     wb_valid, wb_regwrite, wb_rd, wb_data);
        end
        in_valid = 1'b0;
        @(negedge clk);
        // Idle slot: valid/regwrite drop, data and rd hold
        checks++;
        if ({wb_valid, wb_regwrite, wb_rd, wb_data, dmem_bus.dmem_req} !==
            {1'b0, 1'b0, 5'd5, 32'h0000_1234, 1'b0}) begin
            errors++;
            $display("FAIL idle_hold: got v=%b rw=%b rd=%0d data=%h req=%b expected v=0 rw=0 rd=5 data=00001234 req=0",
                     wb_valid, wb_regwrite, wb_rd, wb_data, dmem_bus.dmem_req);
        end
    endtask

    task automatic test_back_to_back();
        drive_instr(OpAlu, 3'b000, 32'hAAAA_0001, 32'h0, 5'd10, 1'b1);
        @(negedge clk);
        checks++;
        if ({wb_valid, wb_regwrite, wb_rd, wb_data} !== {1'b1, 1'b1, 5'd10, 32'hAAAA_0001}) begin
            errors++;
            $display("FAIL b2b_first: got v=%b rw=%b rd=%0d data=%h expected v=1 rw=1 rd=10 data=aaaa0001",
                     wb_valid, wb_regwrite, wb_rd, wb_data);
        end
        // Second instruction targets x0: no register write
        drive_instr(OpAlu, 3'b000, 32'h5555_0002, 32'h0, 5'd0, 1'b1);
        @(negedge clk);
        checks++;
        if ({wb_valid, wb_regwrite, wb_rd, wb_data} !== {1'b1, 1'b0, 5'd0, 32'h5555_0002}) begin
            errors++;
            $display("FAIL b2b_x0: got v=%b rw=%b rd=%0d data=%h expected v=1 rw=0 rd=0 data=55550002",
                     wb_valid, wb_regwrite, wb_rd, wb_data);
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lb();
        drive_instr(OpLoad, 3'b000, 32'h0000_1003, 32'h0, 5'd7, 1'b1);
        #1;
        checks++;
        if ({stall_out, dmem_bus.dmem_req} !== 2'b10) begin
            errors++;
            $display("FAIL lb_idle_stall: got %b expected 10", {stall_out, dmem_bus.dmem_req});
        end
        // Two request cycles with no grant
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_wstrb, dmem_bus.dmem_addr,
                 stall_out, wb_valid} !== {1'b1, 1'b0, 4'b0000, 32'h0000_1000, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL lb_req%0d: got req=%b we=%b strb=%b addr=%h stall=%b wbv=%b expected req=1 we=0 strb=0000 addr=00001000 stall=1 wbv=0",
                         i, dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_wstrb,
                         dmem_bus.dmem_addr, stall_out, wb_valid);
            end
        end
        @(negedge clk);
        dmem_bus.dmem_gnt = 1'b1;
        #1;
        checks++;
        if ({dmem_bus.dmem_req, stall_out} !== 2'b11) begin
            errors++;
            $display("FAIL lb_gnt_stall: got %b expected 11", {dmem_bus.dmem_req, stall_out});
        end
        @(negedge clk);
        dmem_bus.dmem_gnt   = 1'b0;
        dmem_bus.dmem_rvalid = 1'b1;
        dmem_bus.dmem_rdata  = 32'h80FF_0000;
        in_valid = 1'b0;
        #1;
        checks++;
        if ({dmem_bus.dmem_req, stall_out, wb_valid} !== 3'b000) begin
            errors++;
            $display("FAIL lb_rvalid_cycle: got %b expected 000", {dmem_bus.dmem_req, stall_out, wb_valid});
        end
        @(negedge clk);
        dmem_bus.dmem_rvalid = 1'b0;
        checks++;
        if ({wb_valid, wb_regwrite, wb_rd, wb_data} !== {1'b1, 1'b1, 5'd7, 32'hFFFF_FF80}) begin
            errors++;
            $display("FAIL lb_wb: got v=%b rw=%b rd=%0d data=%h expected v=1 rw=1 rd=7 data=ffffff80",
                     wb_valid, wb_regwrite, wb_rd, wb_data);
        end
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL lb_single_pulse: got %b expected 0", wb_valid);
        end
    endtask

    task automatic test_sh();
        drive_instr(OpStore, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 5'd0, 1'b0);
        @(negedge clk);
        dmem_bus.dmem_gnt = 1'b1;
        in_valid = 1'b0;
        #1;
        checks++;
        if ({dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_wstrb, dmem_bus.dmem_wdata,
             dmem_bus.dmem_addr, stall_out} !==
            {1'b1, 1'b1, 4'b1100, 32'hBEEF_BEEF, 32'h0000_2000, 1'b0}) begin
            errors++;
            $display("FAIL sh_bus: got req=%b we=%b strb=%b wdata=%h addr=%h stall=%b expected req=1 we=1 strb=1100 wdata=beefbeef addr=00002000 stall=0",
                     dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_wstrb,
                     dmem_bus.dmem_wdata, dmem_bus.dmem_addr, stall_out);
        end
        @(negedge clk);
        dmem_bus.dmem_gnt = 1'b0;
        checks++;
        if ({wb_valid, wb_regwrite, dmem_bus.dmem_req, mem_exc} !== 4'b1000) begin
            errors++;
            $display("FAIL sh_wb: got %b expected 1000", {wb_valid, wb_regwrite, dmem_bus.dmem_req, mem_exc});
        end
        @(negedge clk);
    endtask

    task automatic test_sb();
        drive_instr(OpStore, 3'b000, 32'h0000_0011, 32'h1234_56A5, 5'd0, 1'b0);
        @(negedge clk);
        dmem_bus.dmem_gnt = 1'b1;
        in_valid = 1'b0;
        #1;
        checks++;
        if ({dmem_bus.dmem_wstrb, dmem_bus.dmem_wdata, dmem_bus.dmem_addr} !==
            {4'b0010, 32'hA5A5_A5A5, 32'h0000_0010}) begin
            errors++;
            $display("FAIL sb_bus: got strb=%b wdata=%h addr=%h expected strb=0010 wdata=a5a5a5a5 addr=00000010",
                     dmem_bus.dmem_wstrb, dmem_bus.dmem_wdata, dmem_bus.dmem_addr);
        end
        @(negedge clk);
        dmem_bus.dmem_gnt = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_misaligned();
        drive_instr(OpLoad, 3'b010, 32'h0000_3001, 32'h0, 5'd9, 1'b1);
        #1;
        checks++;
        if ({stall_out, dmem_bus.dmem_req} !== 2'b00) begin
            errors++;
            $display("FAIL mis_stall: got %b expected 00", {stall_out, dmem_bus.dmem_req});
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if ({wb_valid, wb_regwrite, mem_exc, exc_addr, dmem_bus.dmem_req} !==
            {1'b1, 1'b0, 1'b1, 32'h0000_3001, 1'b0}) begin
            errors++;
            $display("FAIL mis_exc: got v=%b rw=%b exc=%b addr=%h req=%b expected v=1 rw=0 exc=1 addr=00003001 req=0",
                     wb_valid, wb_regwrite, mem_exc, exc_addr, dmem_bus.dmem_req);
        end
        @(negedge clk);
        checks++;
        if ({mem_exc, wb_valid} !== 2'b00) begin
            errors++;
            $display("FAIL mis_pulse: got %b expected 00", {mem_exc, wb_valid});
        end
        // Store with funct3=011 is illegal
        drive_instr(OpStore, 3'b011, 32'h0000_0040, 32'h0, 5'd0, 1'b0);
        #1;
        checks++;
        if (stall_out !== 1'b0) begin
            errors++;
            $display("FAIL ill_store_stall: got %b expected 0", stall_out);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({wb_valid, wb_regwrite, mem_exc, exc_addr} !== {1'b1, 1'b0, 1'b1, 32'h0000_0040}) begin
            errors++;
            $display("FAIL ill_store_exc: got v=%b rw=%b exc=%b addr=%h expected v=1 rw=0 exc=1 addr=00000040",
                     wb_valid, wb_regwrite, mem_exc, exc_addr);
        end
        @(negedge clk);
    endtask

    task automatic test_lhu_lw_x0();
        drive_instr(OpLoad, 3'b101, 32'h0000_4002, 32'h0, 5'd3, 1'b1);
        @(negedge clk);
        dmem_bus.dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_bus.dmem_gnt = 1'b0;
        #1;
        checks++;
        if ({stall_out, dmem_bus.dmem_req, wb_valid} !== 3'b100) begin
            errors++;
            $display("FAIL lhu_wait: got %b expected 100", {stall_out, dmem_bus.dmem_req, wb_valid});
        end
        @(negedge clk);
        dmem_bus.dmem_rvalid = 1'b1;
        dmem_bus.dmem_rdata  = 32'h8001_ABCD;
        in_valid = 1'b0;
        @(negedge clk);
        dmem_bus.dmem_rvalid = 1'b0;
        checks++;
        if ({wb_valid, wb_regwrite, wb_rd, wb_data} !== {1'b1, 1'b1, 5'd3, 32'h0000_8001}) begin
            errors++;
            $display("FAIL lhu_wb: got v=%b rw=%b rd=%0d data=%h expected v=1 rw=1 rd=3 data=00008001",
                     wb_valid, wb_regwrite, wb_rd, wb_data);
        end
        // LW to x0
        drive_instr(OpLoad, 3'b010, 32'h0000_5000, 32'h0, 5'd0, 1'b1);
        @(negedge clk);
        dmem_bus.dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_bus.dmem_gnt    = 1'b0;
        dmem_bus.dmem_rvalid = 1'b1;
        dmem_bus.dmem_rdata  = 32'h1234_5678;
        in_valid = 1'b0;
        @(negedge clk);
        dmem_bus.dmem_rvalid = 1'b0;
        checks++;
        if ({wb_valid, wb_regwrite, wb_data} !== {1'b1, 1'b0, 32'h1234_5678}) begin
            errors++;
            $display("FAIL lw_x0_wb: got v=%b rw=%b data=%h expected v=1 rw=0 data=12345678",
                     wb_valid, wb_regwrite, wb_data);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_in_wait();
        drive_instr(OpLoad, 3'b010, 32'h0000_6000, 32'h0, 5'd4, 1'b1);
        @(negedge clk);
        dmem_bus.dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_bus.dmem_gnt = 1'b0;
        #1;
        checks++;
        if (stall_out !== 1'b1) begin
            errors++;
            $display("FAIL rst_wait_pre: got stall=%b expected 1", stall_out);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({dmem_bus.dmem_req, stall_out} !== 2'b00) begin
            errors++;
            $display("FAIL rst_wait_drop: got %b expected 00", {dmem_bus.dmem_req, stall_out});
        end
        checks++;
        if ({wb_valid, wb_regwrite, mem_exc, wb_rd, wb_data, exc_addr} !== 72'h0) begin
            errors++;
            $display("FAIL rst_wait_outs: got %h expected 0",
                     {wb_valid, wb_regwrite, mem_exc, wb_rd, wb_data, exc_addr});
        end
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        dmem_bus.dmem_rvalid = 1'b1;
        dmem_bus.dmem_gnt    = 1'b1;
        dmem_bus.dmem_rdata  = 32'hCAFE_F00D;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({wb_valid, wb_regwrite, dmem_bus.dmem_req, stall_out} !== 4'b0000) begin
                errors++;
                $display("FAIL rst_late_resp%0d: got %b expected 0000", i,
                         {wb_valid, wb_regwrite, dmem_bus.dmem_req, stall_out});
            end
        end
        dmem_bus.dmem_rvalid = 1'b0;
        dmem_bus.dmem_gnt    = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset                = 1'b1;
        in_valid             = 1'b0;
        alu_result_in        = 32'h0;
        rs2_data_in          = 32'h0;
        funct3_in            = 3'b000;
        rd_in                = 5'd0;
        regwrite_in          = 1'b0;
        op_in                = 7'h0;
        dmem_bus.dmem_gnt    = 1'b0;
        dmem_bus.dmem_rvalid = 1'b0;
        dmem_bus.dmem_rdata  = 32'h0;

        test_reset();
        test_passthrough();
        test_back_to_back();
        test_lb();
        test_sh();
        test_sb();
        test_misaligned();
        test_lhu_lw_x0();
        test_reset_in_wait();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Memory-access stage of the 5-stage RISC-V core. It sits between the EX/MEM pipeline register and the MEM/WB register.
- Executes RV32I loads and stores against a request/grant/response data-memory port.
- Performs byte-lane steering, write-strobe generation, and load sign/zero extension.
- Passes non-memory results straight through.
- Stalls upstream stages while a memory transaction is outstanding.

Parameters:
None.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  EX/MEM slot holds a valid instruction
alu_result_in  input  32  ALU result / effective address
rs2_data_in  input  32  store data
funct3_in  input  3  access size/sign
rd_in  input  5  destination register
regwrite_in  input  1  instruction writes rd
op_in  input  7  opcode
stall_out  output  1  upstream must hold EX/MEM contents (combinational)
dmem_req  output  1  memory request
dmem_we  output  1  1 = store
dmem_addr  output  32  word-aligned address
dmem_wstrb  output  4  byte write enables
dmem_wdata  output  32  lane-replicated store data
dmem_gnt  input  1  request accepted
dmem_rvalid  input  1  load data valid
dmem_rdata  input  32  load data
wb_valid  output  1  MEM/WB slot valid (registered)
wb_data  output  32  writeback value
wb_rd  output  5  writeback register
wb_regwrite  output  1  write enable to register file
mem_exc  output  1  misaligned/illegal access pulse
exc_addr  output  32  faulting address

Behaviour:
- Reset state:
  - Reset clears all registered outputs to 0 and sets the FSM to IDLE.
  - dmem_req and stall_out drop immediately.
- Opcode decode: LOAD = 0000011, STORE = 0100011; every other opcode is non-memory.
- Non-memory instructions:
  - In IDLE with in_valid=1 and a non-memory op, the next edge sets wb_valid=1, wb_data=alu_result_in, wb_rd=rd_in, wb_regwrite=regwrite_in & (rd_in!=0).
  - stall_out stays 0.
- Idle slot: in IDLE with in_valid=0, wb_valid=0 and wb_regwrite=0; wb_data and wb_rd hold their previous values.
- Illegal access:
  - Illegal cases: load funct3 in {011,110,111}; store funct3 >= 011; halfword with addr[0]=1; word with addr[1:0]!=00.
  - No memory request is issued and no stall occurs.
  - Next edge: wb_valid=1, wb_regwrite=0, mem_exc=1 for one cycle, exc_addr=alu_result_in.
- Legal access:
  - In IDLE, stall_out=1 combinationally.
  - At the edge, address, funct3, rd, regwrite, store data and direction are captured, and the FSM moves to REQ.
- FSM:
  - IDLE: as described above.
  - REQ: dmem_req=1 with stable addr/we/wstrb/wdata until dmem_gnt=1.
    - On gnt for a store: go to IDLE; next edge sets wb_valid=1, wb_regwrite=0.
    - On gnt for a load: go to WAIT.
  - WAIT: dmem_req=0. On dmem_rvalid: go to IDLE; next edge sets wb_valid=1 with extended data and wb_regwrite=regwrite & (rd!=0).
- stall_out:
  - = (IDLE & in_valid & legal memory op) | REQ | WAIT.
  - Exception: stall_out is 0 in the REQ cycle where a store is granted and in the WAIT cycle where dmem_rvalid=1, so upstream advances on the same edge the FSM returns to IDLE.
- Store data steering:
  - dmem_addr={addr[31:2],00}.
  - SB: wdata={4{rs2[7:0]}}, wstrb=0001<<addr[1:0].
  - SH: wdata={2{rs2[15:0]}}, wstrb=0011<<addr[1:0].
  - SW: wdata=rs2, wstrb=1111.
  - For loads, wstrb=0000 and we=0.
- Load extraction:
  - Byte/halfword lane is selected by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Memory protocol rules:
  - dmem_rvalid is sampled only in WAIT; rvalid in IDLE or REQ is ignored.
  - Memory returns rvalid at least one cycle after gnt.
  - dmem_gnt is ignored outside REQ.
- wb_valid is 0 during every cycle spent in REQ/WAIT; exactly one wb_valid pulse occurs per instruction.
- Reset mid-transaction:
  - The FSM returns to IDLE and no writeback occurs for the aborted instruction.
  - A late gnt/rvalid is ignored.

Test Plan:
- Pass-through: op=0110011, alu=0x00001234, rd=5, regwrite=1 -> next cycle wb_valid=1, wb_data=0x00001234, wb_rd=5, wb_regwrite=1; stall_out=0; dmem_req never asserted.
- LB: addr=0x00001003, funct3=000, gnt 2 cycles after req, rdata=0x80FF0000 one cycle after gnt -> dmem_addr=0x00001000, wstrb=0000, stall_out high until the rvalid cycle, wb_data=0xFFFFFF80.
- SH: addr=0x00002002, rs2=0xDEADBEEF, immediate gnt -> dmem_we=1, wstrb=1100, wdata=0xBEEFBEEF, dmem_addr=0x00002000; cycle after gnt wb_valid=1, wb_regwrite=0.
- Misaligned LW: addr=0x00003001 -> no dmem_req; next cycle wb_valid=1, wb_regwrite=0, mem_exc=1 for one cycle, exc_addr=0x00003001.
- LHU / LW to x0: LHU addr=0x00004002, rdata=0x8001ABCD -> wb_data=0x00008001. LW with rd=0 -> wb_valid=1, wb_regwrite=0.
- Reset in WAIT: assert reset -> dmem_req=0, stall_out=0 immediately, all outputs 0; rvalid=1 two cycles after reset release -> wb_valid stays 0.
